tmr_vote_monitor: RTL
=====================

Name: tmr_vote_monitor

Overview:
- Registered downstream stage for the triple-modular-redundant data path.
- Takes the three replica words and outputs their bitwise majority through a one-deep valid/ready output register.
- Tracks which replica disagreed with the vote and counts consecutive disagreements per replica.
- Declares a replica faulty after a programmable run of disagreements and keeps a saturating total-error count for power/reliability evaluation.

Parameters:
- data_len, 16, width of each replica word and of the voted output.
- FAULT_THRESH, 4, consecutive accepted words with a lane mismatch that mark that lane faulty (legal range 1..2^CNT_W-1).
- CNT_W, 8, width of the per-lane run counters and of the total error counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a/b/c hold a word to be voted.
- in_ready  output  1  stage can accept a word this cycle.
- a  input  data_len  replica 0.
- b  input  data_len  replica 1.
- c  input  data_len  replica 2.
- out_valid  output  1  out_data/lane_err hold a voted word.
- out_ready  input  1  consumer takes the word this cycle.
- out_data  output  data_len  registered majority (a&b)|(b&c)|(a&c).
- lane_err  output  3  per-lane mismatch, registered alongside out_data. Bit0 = a, bit1 = b, bit2 = c.
- lane_faulty  output  3  sticky per-lane fault flags.
- multi_err  output  1  sticky; set when an accepted word had two or more lane_err bits set.
- err_count  output  CNT_W  saturating count of accepted words with any lane mismatch.
- clear_faults  input  1  synchronous clear of all monitor state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0, out_data=0, lane_err=0, lane_faulty=0, multi_err=0, err_count=0, all run counters 0, all lane states OK. in_ready=1 once reset is released.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - On accept, out_data, lane_err and out_valid=1 load on the next edge. Latency is 1 cycle.
  - Back-to-back accepts are allowed while out_ready=1: full throughput, no bubble.
  - If out_valid=1 && out_ready=0, out_data and lane_err hold stable and in_ready=0.
  - Pop without accept clears out_valid.
- Mismatch: lane_err[i] = (replica_i != vote), evaluated on the accepted word only. Non-accepted cycles leave all monitor state unchanged.
- Per-lane FSM, updated only on accept:
  - OK:
    - mismatch -> run=1.
    - If FAULT_THRESH==1 -> FAULTY; else -> SUSPECT.
    - Match -> stay OK.
  - SUSPECT:
    - mismatch -> run+1.
    - If run+1==FAULT_THRESH -> FAULTY; else stay SUSPECT.
    - Match -> run=0, -> OK.
  - FAULTY:
    - Sticky, lane_faulty[i]=1.
    - Run counter frozen; further mismatches are ignored by the FSM.
    - Exited only by clear_faults or reset.
- Lane faults do not change voting: out_data is always the plain majority.
- err_count: +1 on each accepted word with |lane_err != 0. Saturates at 2^CNT_W-1, no wrap.
- multi_err: set on an accepted word with popcount(lane_err) >= 2. Sticky until clear_faults or reset.
- clear_faults (one cycle, synchronous):
  - Zeroes lane_faulty, multi_err, err_count and run counters; all FSMs go to OK.
  - Does not touch out_valid, out_data or lane_err.
  - Clear with a simultaneous accept: clear wins for monitor state. The word is still voted and passed through, and its mismatches are not counted.
- Reset mid-transfer: the held word is discarded and out_valid drops immediately (asynchronous).
- All outputs are registered except in_ready.

Test Plan:
- Reset, then a=b=c=16'h1234 with in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=16'h1234, lane_err=3'b000, err_count=0.
- Four consecutive words with c=16'h0000, a=b=16'hFFFF -> out_data=16'hFFFF and lane_err=3'b100 each word. lane_faulty=3'b100 after the 4th accept, err_count=4.
- c mismatches three times, then one matching word, then mismatches three more -> lane_faulty stays 0, err_count=6.
- a=16'h0001, b=16'h0002, c=16'h0000 -> out_data=16'h0000, lane_err=3'b011, multi_err=1.
- Hold out_ready=0 with a word in the register and keep changing inputs -> in_ready=0, out_data/lane_err stable. Raise out_ready -> next word is accepted the same cycle.
- Drive 300 mismatching words (CNT_W=8) -> err_count saturates at 255. Then clear_faults during an accept -> err_count=0, lane_faulty=0, and the accepted word appears on out_data next cycle.

Source files
------------

// File: rtl/tmr_vote_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tmr_vote_monitor
// Description : Registered bitwise majority voter for a triple-modular-
//               redundant data path with a one-deep valid/ready output
//               register, per-lane mismatch tracking, sticky fault flags,
//               a multi-lane error flag and a saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tmr_vote_monitor #(
    parameter int data_len     = 16,
    parameter int FAULT_THRESH = 4,
    parameter int CNT_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [data_len-1:0] a,
    input  logic [data_len-1:0] b,
    input  logic [data_len-1:0] c,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [data_len-1:0] out_data,
    output logic [2:0]          lane_err,
    output logic [2:0]          lane_faulty,
    output logic                multi_err,
    output logic [CNT_W-1:0]    err_count,
    input  logic                clear_faults
);

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULTY  = 2'd2
    } lane_state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_THRESH  = CNT_W'(FAULT_THRESH);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    logic                w_accept;
    logic [data_len-1:0] w_vote;
    logic [2:0]          w_lane_err;
    logic                w_multi;
    logic [2:0]          w_lane_faulty;

    logic                r_out_valid;
    logic [data_len-1:0] r_out_data;
    logic [2:0]          r_lane_err;
    logic                r_multi_err;
    logic [CNT_W-1:0]    r_err_count;

    // Skid-free one-deep register: a new word may enter whenever the held
    // word is absent or leaving this cycle.
    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;

    assign w_vote     = (a & b) | (b & c) | (a & c);
    assign w_lane_err = {(c != w_vote), (b != w_vote), (a != w_vote)};
    // Two or more lanes disagreeing with the vote
    assign w_multi    = (w_lane_err[0] & w_lane_err[1]) |
                        (w_lane_err[1] & w_lane_err[2]) |
                        (w_lane_err[0] & w_lane_err[2]);

    // Output register: load on accept, drop valid on a pop with no refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_lane_err  <= 3'b000;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_vote;
            r_lane_err  <= w_lane_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky multi-lane flag and saturating error counter; clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_multi_err <= 1'b0;
            r_err_count <= '0;
        end else if (clear_faults) begin
            r_multi_err <= 1'b0;
            r_err_count <= '0;
        end else if (w_accept) begin
            if (w_multi) begin
                r_multi_err <= 1'b1;
            end
            if ((|w_lane_err) && (r_err_count != C_CNT_MAX)) begin
                r_err_count <= r_err_count + C_ONE;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            lane_state_t      r_state;
            lane_state_t      w_state_nxt;
            logic [CNT_W-1:0] r_run;
            logic [CNT_W-1:0] w_run_nxt;
            logic             r_faulty;

            // Next-state logic for the lane's consecutive-mismatch tracker
            always_comb begin
                w_state_nxt = r_state;
                w_run_nxt   = r_run;
                if (clear_faults) begin
                    w_state_nxt = ST_OK;
                    w_run_nxt   = '0;
                end else if (w_accept) begin
                    case (r_state)
                        ST_OK: begin
                            if (w_lane_err[gi]) begin
                                w_run_nxt   = C_ONE;
                                w_state_nxt = (C_THRESH == C_ONE) ? ST_FAULTY : ST_SUSPECT;
                            end
                        end
                        ST_SUSPECT: begin
                            if (w_lane_err[gi]) begin
                                w_run_nxt   = r_run + C_ONE;
                                w_state_nxt = ((r_run + C_ONE) == C_THRESH) ? ST_FAULTY : ST_SUSPECT;
                            end else begin
                                w_run_nxt   = '0;
                                w_state_nxt = ST_OK;
                            end
                        end
                        ST_FAULTY: begin
                            // Sticky; run counter frozen until cleared
                        end
                        default: begin
                            w_state_nxt = ST_OK;
                            w_run_nxt   = '0;
                        end
                    endcase
                end
            end

            // Lane state, run counter and registered fault flag
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state  <= ST_OK;
                    r_run    <= '0;
                    r_faulty <= 1'b0;
                end else begin
                    r_state  <= w_state_nxt;
                    r_run    <= w_run_nxt;
                    r_faulty <= (w_state_nxt == ST_FAULTY);
                end
            end

            assign w_lane_faulty[gi] = r_faulty;
        end
    endgenerate

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign lane_err    = r_lane_err;
    assign lane_faulty = w_lane_faulty;
    assign multi_err   = r_multi_err;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire
